// File: rtl/mux_rr_sel_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux_sel_pkg
// Shared definitions for the 4:1 mux select arbiter and its helpers:
//   - arb_state_e  : arbiter state encoding (IDLE / GRANT)
//   - N_CH, SEL_W  : channel count and select width
//   - *_DEF        : default timing parameters for the arbiter
//   - sel_to_onehot: converts a select index into a one-hot grant vector
// -----------------------------------------------------------------------------
package mux_sel_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  localparam int HOLD_CYCLES_DEF = 4;
  localparam int TIMEOUT_DEF     = 15;
  localparam int CNT_W_DEF       = 4;

  function automatic logic [N_CH-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
    logic [N_CH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_rr_sel_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux_rr_sel_arbiter_if
// Bundles the request/consume handshake and the registered mux-select outputs.
//   req[3:0]  : per-source request, bit i maps to mux input Ii
//   done      : consumer finished with the current source
//   S1, S0    : mux select pair
//   grant[3:0]: one-hot grant, zero when idle
//   out_valid : mux output is meaningful
//   timeout   : one-cycle pulse after a forced release
// Modports:
//   master : the arbiter side (drives selects/grant/status)
//   slave  : the requester/consumer side (drives req/done)
// -----------------------------------------------------------------------------
interface mux_rr_sel_arbiter_if;
  import mux_sel_pkg::*;

  logic [N_CH-1:0] req;
  logic            done;
  logic            S0;
  logic            S1;
  logic [N_CH-1:0] grant;
  logic            out_valid;
  logic            timeout;

  modport master (
    input  req,
    input  done,
    output S0,
    output S1,
    output grant,
    output out_valid,
    output timeout
  );

  modport slave (
    output req,
    output done,
    input  S0,
    input  S1,
    input  grant,
    input  out_valid,
    input  timeout
  );

endinterface

// File: rtl/mux_rr_sel_arbiter_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational 4-way round-robin picker.
//   req[3:0]  in  : request vector
//   last[1:0] in  : index served most recently (lowest priority this round)
//   any       out : at least one request is set
//   win[1:0]  out : first set request scanning upward from last+1, modulo 4
// -----------------------------------------------------------------------------
module rr_pick4
  import mux_sel_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  // rot[k] is the request of channel last+1+k, so rot[0] is highest priority
  // and rot[N_CH-1] is the last-served channel itself.
  logic [N_CH-1:0]  rot;
  logic [SEL_W-1:0] offset;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_rot
      assign rot[gi] = req[SEL_W'(last + SEL_W'(gi + 1))];
    end
  endgenerate

  // Scan from the lowest priority upward so the lowest set position wins.
  always_comb begin
    offset = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        offset = SEL_W'(i);
      end
    end
  end

  assign any = |req;
  assign win = SEL_W'(last + offset + SEL_W'(1));

endmodule

// File: rtl/mux_rr_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_sel_arbiter
// Round-robin arbiter that drives the select pair of a 4:1 bit multiplexer.
// A winning source keeps the mux until it withdraws its request, the
// consumer signals done after the minimum hold time, or the grant ages out.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : mux_rr_sel_arbiter_if.master (req/done in; S1/S0, grant,
//            out_valid, timeout out -- all outputs registered)
// Parameters:
//   HOLD_CYCLES : minimum grant length before done is honoured (>=1)
//   TIMEOUT     : grant length at which release is forced (> HOLD_CYCLES)
//   CNT_W       : grant-age counter width, 2**CNT_W > TIMEOUT
// -----------------------------------------------------------------------------
module mux_rr_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_rr_sel_arbiter_if.master bus
);

  arb_state_e       state_q,   state_d;
  logic [SEL_W-1:0] sel_q,     sel_d;
  logic [SEL_W-1:0] last_q,    last_d;
  logic [N_CH-1:0]  grant_q,   grant_d;
  logic             valid_q,   valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic [SEL_W-1:0] pick_last;
  logic [SEL_W-1:0] win;
  logic             any_req;
  logic             withdraw;
  logic             hit_timeout;
  logic             hit_done;
  logic             release_now;

  // While granting, the picker only matters in a release cycle, where the
  // current channel becomes the last-served one. Kept outside the main
  // always_comb so the picker does not form an apparent loop with it.
  assign pick_last = (state_q == GRANT) ? sel_q : last_q;

  rr_pick4 u_pick (
    .req  (bus.req),
    .last (pick_last),
    .any  (any_req),
    .win  (win)
  );

  assign withdraw    = ~bus.req[sel_q];
  assign hit_timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign hit_done    = bus.done && (cnt_q >= CNT_W'(HOLD_CYCLES - 1));
  assign release_now = withdraw | hit_timeout | hit_done;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        // Selects keep their old value so the mux does not glitch.
        grant_d = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
        if (any_req) begin
          state_d = GRANT;
          sel_d   = win;
          grant_d = sel_to_onehot(win);
          valid_d = 1'b1;
        end
      end

      GRANT: begin
        if (cnt_q != CNT_W'(TIMEOUT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (release_now) begin
          last_d = sel_q;
          cnt_d  = '0;
          // A withdrawal wins over an expiring grant: no pulse then.
          timeout_d = hit_timeout & ~withdraw;
          if (any_req) begin
            // Back-to-back hand-over; out_valid stays high.
            sel_d   = win;
            grant_d = sel_to_onehot(win);
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      last_q    <= SEL_W'(N_CH - 1);
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.S1        = sel_q[1];
  assign bus.S0        = sel_q[0];
  assign bus.grant     = grant_q;
  assign bus.out_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_mux_rr_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_sel_arbiter
// Self-checking bench for mux_rr_sel_arbiter. Each step drives inputs for one
// clock, queues the outputs expected after that edge, and compares them
// against the DUT once the edge has passed.
// -----------------------------------------------------------------------------
module tb_mux_rr_sel_arbiter;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       tmo;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       tmo;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  vec_t tbl[14];

  mux_rr_sel_arbiter_if bus_if ();

  mux_rr_sel_arbiter #(
    .HOLD_CYCLES (4),
    .TIMEOUT     (15),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  task automatic step(input logic r, input logic [3:0] rq, input logic d,
                      input logic [1:0] es, input logic [3:0] eg,
                      input logic ev, input logic et, input string nm);
    exp_t e;
    logic [1:0] s_act;
    rst_n       = r;
    bus_if.req  = rq;
    bus_if.done = d;
    e.sel   = es;
    e.grant = eg;
    e.valid = ev;
    e.tmo   = et;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e      = sb_q.pop_front();
    s_act  = {bus_if.S1, bus_if.S0};
    checks = checks + 1;
    if ({s_act, bus_if.grant, bus_if.out_valid, bus_if.timeout} !==
        {e.sel, e.grant, e.valid, e.tmo}) begin
      errors = errors + 1;
      $display("FAIL %s: got S=%b grant=%b v=%b t=%b, expected S=%b grant=%b v=%b t=%b",
               nm, s_act, bus_if.grant, bus_if.out_valid, bus_if.timeout,
               e.sel, e.grant, e.valid, e.tmo);
    end else begin
      $display("chk %0d %s: S=%b grant=%b v=%b t=%b", checks, nm, s_act,
               bus_if.grant, bus_if.out_valid, bus_if.timeout);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus_if.req  = 4'b0000;
    bus_if.done = 1'b0;

    // {rst_n, req, done, exp S1S0, exp grant, exp out_valid, exp timeout}
    tbl[0]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0}; // reset
    tbl[1]  = '{1'b1, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0}; // first grant, cnt0
    tbl[2]  = '{1'b1, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0}; // cnt0 -> 1
    tbl[3]  = '{1'b1, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0}; // done at cnt1 ignored
    tbl[4]  = '{1'b1, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0}; // cnt2 -> 3
    tbl[5]  = '{1'b1, 4'b0011, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0}; // done at cnt3 -> ch1
    tbl[6]  = '{1'b1, 4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0}; // withdraw -> idle
    tbl[7]  = '{1'b1, 4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0}; // idle keeps select
    tbl[8]  = '{1'b1, 4'b1000, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0}; // grant ch3
    tbl[9]  = '{1'b1, 4'b1011, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0}; // cnt0 -> 1
    tbl[10] = '{1'b1, 4'b1011, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0}; // cnt1 -> 2
    tbl[11] = '{1'b1, 4'b0011, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0}; // drop ch3 at cnt2 -> ch0
    tbl[12] = '{1'b1, 4'b0011, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0}; // holds ch0
    tbl[13] = '{1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0}; // withdraw -> idle

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst_n, tbl[i].req, tbl[i].done, tbl[i].sel, tbl[i].grant,
           tbl[i].valid, tbl[i].tmo, $sformatf("vec%0d", i));
    end

    // Round-robin with all channels requesting and done held high:
    // each grant lasts exactly HOLD_CYCLES with no out_valid gap.
    step(1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, "rr_reset");
    step(1'b1, 4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, "rr_first");
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 4; k++) begin
        int ch;
        ch = (k < 3) ? (g % 4) : ((g + 1) % 4);
        step(1'b1, 4'b1111, 1'b1, 2'(ch), oh(ch), 1'b1, 1'b0,
             $sformatf("rr_g%0d_c%0d", g, k));
      end
    end

    // Lone requester on ch2 without done: forced release after 15 cycles.
    // Round 0: plain timeout. Round 1: done on the timeout cycle (pulse).
    // Round 2: req drop on the timeout cycle (withdrawal, no pulse).
    step(1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, "to_reset");
    step(1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, "to_grant");
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < 14; k++) begin
        step(1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0,
             $sformatf("to_r%0d_c%0d", rep, k));
      end
      if (rep == 0) begin
        step(1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b1, "to_expire");
      end else if (rep == 1) begin
        step(1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1, "to_with_done");
      end else begin
        step(1'b1, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0, "to_with_drop");
      end
    end
    step(1'b1, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0, "to_no_late_pulse");

    // Reset in the middle of a ch2 grant at cnt=10, then check the pointer
    // is back at 3 (ch2 beats ch3 with req=1100).
    step(1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, "mid_grant");
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0,
           $sformatf("mid_c%0d", k));
    end
    step(1'b0, 4'b0100, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, "mid_reset");
    step(1'b1, 4'b1100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, "ptr_after_reset");
    step(1'b1, 4'b1100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, "ptr_hold");
    step(1'b1, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0, "final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
